// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_if
// Description : Bundles the cache-side refill handshakes and the AXI read
//               address/data channel seen by axi_rd_arbiter.
//               master modport : arbiter view (AXI read master, cache server)
//               slave  modport : environment view (caches + interconnect)
// Ports       : ic_* / dc_*    cache refill request, grant and beat strobes
//               rd_rdata/beat  shared data return bus and beat index
//               ar* / r*       AXI read address and read data channels
//               busy           arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rd_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              ic_rd_req;
    logic [31:0]       ic_rd_addr;
    logic [7:0]        ic_rd_len;
    logic              ic_addr_ok;
    logic              ic_cancel;
    logic              ic_rvalid;
    logic              ic_rlast;
    logic              dc_rd_req;
    logic [31:0]       dc_rd_addr;
    logic [7:0]        dc_rd_len;
    logic              dc_addr_ok;
    logic              dc_rvalid;
    logic              dc_rlast;
    logic [DATA_W-1:0] rd_rdata;
    logic [7:0]        rd_beat;
    logic [3:0]        arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              busy;

    modport master (
        input  ic_rd_req, ic_rd_addr, ic_rd_len, ic_cancel,
        input  dc_rd_req, dc_rd_addr, dc_rd_len,
        input  arready, rid, rdata, rlast, rvalid,
        output ic_addr_ok, ic_rvalid, ic_rlast,
        output dc_addr_ok, dc_rvalid, dc_rlast,
        output rd_rdata, rd_beat,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready, busy
    );

    modport slave (
        output ic_rd_req, ic_rd_addr, ic_rd_len, ic_cancel,
        output dc_rd_req, dc_rd_addr, dc_rd_len,
        output arready, rid, rdata, rlast, rvalid,
        input  ic_addr_ok, ic_rvalid, ic_rlast,
        input  dc_addr_ok, dc_rvalid, dc_rlast,
        input  rd_rdata, rd_beat,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready, busy
    );
endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Shares one AXI read channel between the ICache and DCache
//               refill engines. One burst at a time: grant in IDLE, AR
//               handshake, then R beats until rlast routed to the owner.
//               An ICache cancel lets the burst drain but hides its beats.
// Ports       : clk    clock
//               resetn asynchronous active-low reset
//               bus    axi_rd_arbiter_if.master (cache + AXI read signals)
// Options     : RD_ARB_ROUND_ROBIN_EN - alternate grants on simultaneous
//               requests instead of fixed DCache priority.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter logic [3:0] IC_ARID = 4'd0,
    parameter logic [3:0] DC_ARID = 4'd1,
    parameter int         DATA_W  = 32
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    axi_rd_arbiter_if.master    bus
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_ar     = 2'd1;
    localparam logic [1:0] c_r      = 2'd2;
    localparam logic       c_own_ic = 1'b0;
    localparam logic       c_own_dc = 1'b1;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_owner;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [3:0]  r_arid;
    logic [7:0]  r_beat;
    logic        r_cancel;
    logic        r_err_id;   // sticky debug flag: a beat arrived with a foreign rid
    logic        w_grant_ic;
    logic        w_grant_dc;
    logic        w_grant_any;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_ic_mute;

`ifdef RD_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On a tie the cache that did not win last time gets the channel.
    always_comb begin
        w_grant_dc = bus.dc_rd_req & (~bus.ic_rd_req | (r_last_grant == c_own_ic));
        w_grant_ic = bus.ic_rd_req & (~bus.dc_rd_req | (r_last_grant == c_own_dc));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= c_own_ic;
        end else if ((r_state == c_idle) && w_grant_any) begin
            r_last_grant <= w_grant_dc;
        end
    end
`else
    assign w_grant_dc = bus.dc_rd_req;
    assign w_grant_ic = bus.ic_rd_req & ~bus.dc_rd_req;
`endif

    assign w_grant_any = w_grant_ic | w_grant_dc;
    assign w_ar_hs     = (r_state == c_ar) & bus.arready;
    assign w_r_hs      = (r_state == c_r) & bus.rvalid;
    // The live cancel input hides a beat in the same cycle it is raised.
    assign w_ic_mute   = r_cancel | bus.ic_cancel;

    assign bus.arid     = r_arid;
    assign bus.araddr   = r_araddr;
    assign bus.arlen    = r_arlen;
    assign bus.arsize   = 3'b010;
    assign bus.arburst  = 2'b01;
    assign bus.rd_rdata = bus.rdata[DATA_W-1:0];
    assign bus.rd_beat  = r_beat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.busy       = 1'b1;
        bus.arvalid    = 1'b0;
        bus.rready     = 1'b0;
        bus.ic_addr_ok = 1'b0;
        bus.dc_addr_ok = 1'b0;
        bus.ic_rvalid  = 1'b0;
        bus.ic_rlast   = 1'b0;
        bus.dc_rvalid  = 1'b0;
        bus.dc_rlast   = 1'b0;
        case (r_state)
            c_idle: begin
                bus.busy = 1'b0;
                // Grants are suppressed while reset is held so requests
                // parked on the inputs cannot pulse addr_ok.
                bus.ic_addr_ok = w_grant_ic & resetn;
                bus.dc_addr_ok = w_grant_dc & resetn;
                if (w_grant_any) begin
                    w_state_nxt = c_ar;
                end
            end
            c_ar: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    w_state_nxt = c_r;
                end
            end
            c_r: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    if (r_owner == c_own_dc) begin
                        bus.dc_rvalid = 1'b1;
                        bus.dc_rlast  = bus.rlast;
                    end else if (!w_ic_mute) begin
                        bus.ic_rvalid = 1'b1;
                        bus.ic_rlast  = bus.rlast;
                    end
                    if (bus.rlast) begin
                        w_state_nxt = c_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner  <= c_own_ic;
            r_araddr <= 32'd0;
            r_arlen  <= 8'd0;
            r_arid   <= IC_ARID;
            r_beat   <= 8'd0;
            r_cancel <= 1'b0;
            r_err_id <= 1'b0;
        end else begin
            if ((r_state == c_idle) && w_grant_any) begin
                r_owner  <= w_grant_dc;
                r_araddr <= w_grant_dc ? bus.dc_rd_addr : bus.ic_rd_addr;
                r_arlen  <= w_grant_dc ? bus.dc_rd_len  : bus.ic_rd_len;
                r_arid   <= w_grant_dc ? DC_ARID        : IC_ARID;
            end
            if (w_ar_hs) begin
                r_beat <= 8'd0;
            end else if (w_r_hs) begin
                r_beat   <= r_beat + 8'd1;
                r_err_id <= r_err_id | (bus.rid != r_arid);
            end
            if ((r_state == c_idle) || (w_r_hs && bus.rlast)) begin
                r_cancel <= 1'b0;
            end else if ((r_owner == c_own_ic) && bus.ic_cancel) begin
                r_cancel <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter. Inputs are
//               driven just after the falling edge and outputs are sampled
//               1ns later, well away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    axi_rd_arbiter_if #(.DATA_W(32)) bus ();

    axi_rd_arbiter #(
        .IC_ARID (4'd0),
        .DC_ARID (4'd1),
        .DATA_W  (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        bus.ic_rd_req  = 1'b0;
        bus.ic_rd_addr = 32'd0;
        bus.ic_rd_len  = 8'd0;
        bus.ic_cancel  = 1'b0;
        bus.dc_rd_req  = 1'b0;
        bus.dc_rd_addr = 32'd0;
        bus.dc_rd_len  = 8'd0;
        bus.arready    = 1'b0;
        bus.rid        = 4'd0;
        bus.rdata      = 32'd0;
        bus.rlast      = 1'b0;
        bus.rvalid     = 1'b0;
    endtask

    // Stimulus only: accepts AR immediately and returns n back-to-back beats.
    // Called while the DUT sits in AR; returns on the falling edge where the
    // DUT is back in IDLE.
    task automatic serve_burst(input int n, input logic [31:0] base);
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = base;
        bus.rlast   = (n == 1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            bus.rdata = base + i;
            bus.rlast = (i == n - 1);
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({bus.busy, bus.arvalid, bus.rready, bus.ic_addr_ok, bus.dc_addr_ok,
             bus.ic_rvalid, bus.ic_rlast, bus.dc_rvalid, bus.dc_rlast} !== 9'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 000000000", {bus.busy, bus.arvalid,
                     bus.rready, bus.ic_addr_ok, bus.dc_addr_ok, bus.ic_rvalid,
                     bus.ic_rlast, bus.dc_rvalid, bus.dc_rlast});
        end
        total++;
        if (bus.rd_beat !== 8'd0) begin
            bad++;
            $display("FAIL reset_beat: got %0d want 0", bus.rd_beat);
        end
        total++;
        if ({bus.arsize, bus.arburst} !== 5'b010_01) begin
            bad++;
            $display("FAIL reset_arconst: got %b want 01001", {bus.arsize, bus.arburst});
        end
        @(negedge clk) resetn = 1'b1;
    endtask

    task automatic test_ic_burst();
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1FC0_0000;
        bus.ic_rd_len  = 8'd3;
        #1;
        total++;
        if ({bus.ic_addr_ok, bus.dc_addr_ok, bus.busy} !== 3'b100) begin
            bad++;
            $display("FAIL ic_grant: got %b want 100", {bus.ic_addr_ok, bus.dc_addr_ok, bus.busy});
        end
        @(negedge clk) bus.ic_rd_req = 1'b0;
        #1;
        total++;
        if ({bus.arvalid, bus.busy, bus.ic_addr_ok} !== 3'b110) begin
            bad++;
            $display("FAIL ic_ar_state: got %b want 110", {bus.arvalid, bus.busy, bus.ic_addr_ok});
        end
        total++;
        if ({bus.arid, bus.araddr, bus.arlen} !== {4'd0, 32'h1FC0_0000, 8'd3}) begin
            bad++;
            $display("FAIL ic_ar_fields: got id=%0d addr=%h len=%0d want id=0 addr=1fc00000 len=3",
                     bus.arid, bus.araddr, bus.arlen);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.arvalid, bus.araddr} !== {1'b1, 32'h1FC0_0000}) begin
            bad++;
            $display("FAIL ic_ar_stable: got valid=%b addr=%h want valid=1 addr=1fc00000",
                     bus.arvalid, bus.araddr);
        end
        @(negedge clk) bus.arready = 1'b1;
        #1;
        total++;
        if ({bus.arvalid, bus.rready} !== 2'b10) begin
            bad++;
            $display("FAIL ic_ar_hs: got %b want 10", {bus.arvalid, bus.rready});
        end
        @(negedge clk) bus.arready = 1'b0;
        #1;
        total++;
        if ({bus.arvalid, bus.rready} !== 2'b01) begin
            bad++;
            $display("FAIL ic_r_state: got %b want 01", {bus.arvalid, bus.rready});
        end
        for (int i = 0; i < 4; i++) begin
            logic [2:0] exp_v;
            @(negedge clk);
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA0 + i;
            bus.rlast  = (i == 3);
            bus.rid    = 4'd0;
            exp_v      = {1'b1, (i == 3), 1'b0};
            #1;
            total++;
            if ({bus.ic_rvalid, bus.ic_rlast, bus.dc_rvalid} !== exp_v) begin
                bad++;
                $display("FAIL ic_beat%0d_strobes: got %b want %b", i,
                         {bus.ic_rvalid, bus.ic_rlast, bus.dc_rvalid}, exp_v);
            end
            total++;
            if ({bus.rd_beat, bus.rd_rdata} !== {8'(i), 32'hA0 + 32'(i)}) begin
                bad++;
                $display("FAIL ic_beat%0d_data: got beat=%0d data=%h want beat=%0d data=%h",
                         i, bus.rd_beat, bus.rd_rdata, i, 32'hA0 + i);
            end
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.rready} !== 2'b00) begin
            bad++;
            $display("FAIL ic_done: got %b want 00", {bus.busy, bus.rready});
        end
    endtask

`ifndef RD_ARB_ROUND_ROBIN_EN
    task automatic test_priority();
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h0000_1000;
        bus.ic_rd_len  = 8'd0;
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_0040;
        bus.dc_rd_len  = 8'd0;
        #1;
        total++;
        if ({bus.dc_addr_ok, bus.ic_addr_ok} !== 2'b10) begin
            bad++;
            $display("FAIL prio_grant: got dc/ic=%b want 10", {bus.dc_addr_ok, bus.ic_addr_ok});
        end
        @(negedge clk) bus.dc_rd_req = 1'b0;
        #1;
        total++;
        if ({bus.arvalid, bus.ic_addr_ok, bus.arid, bus.araddr} !== {2'b10, 4'd1, 32'h8000_0040}) begin
            bad++;
            $display("FAIL prio_dc_ar: got v=%b ok=%b id=%0d addr=%h want v=1 ok=0 id=1 addr=80000040",
                     bus.arvalid, bus.ic_addr_ok, bus.arid, bus.araddr);
        end
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h55;
        bus.rlast   = 1'b1;
        bus.rid     = 4'd1;
        #1;
        total++;
        if ({bus.dc_rvalid, bus.dc_rlast, bus.ic_rvalid, bus.ic_rlast} !== 4'b1100) begin
            bad++;
            $display("FAIL prio_dc_beat: got %b want 1100",
                     {bus.dc_rvalid, bus.dc_rlast, bus.ic_rvalid, bus.ic_rlast});
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        total++;
        if ({bus.ic_addr_ok, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL prio_ic_grant: got ok/busy=%b want 10", {bus.ic_addr_ok, bus.busy});
        end
        @(negedge clk) bus.ic_rd_req = 1'b0;
        #1;
        total++;
        if ({bus.arid, bus.araddr} !== {4'd0, 32'h0000_1000}) begin
            bad++;
            $display("FAIL prio_ic_ar: got id=%0d addr=%h want id=0 addr=00001000", bus.arid, bus.araddr);
        end
        serve_burst(1, 32'h66);
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL prio_done: got busy=%b want 0", bus.busy);
        end
    endtask
`else
    task automatic test_round_robin();
        logic exp_dc [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.ic_rd_req  = 1'b1;
            bus.ic_rd_addr = 32'h0000_2000 + 32'(k);
            bus.dc_rd_req  = 1'b1;
            bus.dc_rd_addr = 32'h8000_2000 + 32'(k);
            #1;
            total++;
            if ({bus.dc_addr_ok, bus.ic_addr_ok} !== {exp_dc[k], ~exp_dc[k]}) begin
                bad++;
                $display("FAIL rr_grant%0d: got dc/ic=%b want %b", k,
                         {bus.dc_addr_ok, bus.ic_addr_ok}, {exp_dc[k], ~exp_dc[k]});
            end
            @(negedge clk);
            bus.ic_rd_req = 1'b0;
            bus.dc_rd_req = 1'b0;
            #1;
            total++;
            if (bus.arid !== (exp_dc[k] ? 4'd1 : 4'd0)) begin
                bad++;
                $display("FAIL rr_arid%0d: got %0d want %0d", k, bus.arid, exp_dc[k] ? 1 : 0);
            end
            serve_burst(1, 32'h70 + 32'(k));
        end
    endtask
`endif

    task automatic test_cancel();
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h0000_3000;
        bus.ic_rd_len  = 8'd3;
        @(negedge clk) bus.ic_rd_req = 1'b0;
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk) bus.arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hB0 + i;
            bus.rid    = 4'd0;
            #1;
            total++;
            if ({bus.ic_rvalid, bus.rd_beat} !== {1'b1, 8'(i)}) begin
                bad++;
                $display("FAIL cancel_pre%0d: got v=%b beat=%0d want v=1 beat=%0d",
                         i, bus.ic_rvalid, bus.rd_beat, i);
            end
        end
        @(negedge clk);
        bus.rvalid    = 1'b0;
        bus.ic_cancel = 1'b1;
        #1;
        total++;
        if ({bus.rready, bus.ic_rvalid} !== 2'b10) begin
            bad++;
            $display("FAIL cancel_pulse: got rready/v=%b want 10", {bus.rready, bus.ic_rvalid});
        end
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            bus.ic_cancel = 1'b0;
            bus.rvalid    = 1'b1;
            bus.rdata     = 32'hB0 + i;
            bus.rlast     = (i == 3);
            #1;
            total++;
            if ({bus.rready, bus.ic_rvalid, bus.ic_rlast, bus.rd_beat} !== {3'b100, 8'(i)}) begin
                bad++;
                $display("FAIL cancel_beat%0d: got rready=%b v=%b last=%b beat=%0d want 1 0 0 %0d",
                         i, bus.rready, bus.ic_rvalid, bus.ic_rlast, bus.rd_beat, i);
            end
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL cancel_done: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_bubbles();
        int gaps [3] = '{1, 3, 2};
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h0000_4000;
        bus.ic_rd_len  = 8'd2;
        @(negedge clk) bus.ic_rd_req = 1'b0;
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk) bus.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                #1;
                total++;
                if ({bus.ic_rvalid, bus.ic_rlast, bus.dc_rvalid, bus.rd_beat} !== {3'b000, 8'(i)}) begin
                    bad++;
                    $display("FAIL bubble%0d_gap%0d: got v=%b l=%b dv=%b beat=%0d want 0 0 0 %0d",
                             i, g, bus.ic_rvalid, bus.ic_rlast, bus.dc_rvalid, bus.rd_beat, i);
                end
            end
            @(negedge clk);
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hC0 + i;
            bus.rid    = (i == 1) ? 4'd5 : 4'd0;
            bus.rlast  = (i == 2);
            #1;
            total++;
            if ({bus.ic_rvalid, bus.ic_rlast, bus.rd_beat, bus.rd_rdata} !==
                {1'b1, (i == 2), 8'(i), 32'hC0 + 32'(i)}) begin
                bad++;
                $display("FAIL bubble%0d_beat: got v=%b l=%b beat=%0d data=%h want 1 %0d %0d %h",
                         i, bus.ic_rvalid, bus.ic_rlast, bus.rd_beat, bus.rd_rdata,
                         (i == 2), i, 32'hC0 + i);
            end
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rid    = 4'd0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL bubble_done: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h0000_5000;
        bus.ic_rd_len  = 8'd3;
        @(negedge clk) bus.ic_rd_req = 1'b0;
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk) bus.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hE0 + i;
        end
        #1;
        total++;
        if ({bus.ic_rvalid, bus.rd_beat} !== {1'b1, 8'd2}) begin
            bad++;
            $display("FAIL areset_pre: got v=%b beat=%0d want v=1 beat=2", bus.ic_rvalid, bus.rd_beat);
        end
        #1 resetn = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.rready, bus.arvalid, bus.ic_rvalid, bus.ic_rlast,
             bus.ic_addr_ok, bus.dc_addr_ok, bus.rd_beat} !== {7'b0, 8'd0}) begin
            bad++;
            $display("FAIL areset_outputs: got busy=%b rr=%b av=%b v=%b l=%b ok=%b%b beat=%0d want all 0",
                     bus.busy, bus.rready, bus.arvalid, bus.ic_rvalid, bus.ic_rlast,
                     bus.ic_addr_ok, bus.dc_addr_ok, bus.rd_beat);
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        resetn     = 1'b1;
        @(negedge clk);
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h0000_6000;
        bus.ic_rd_len  = 8'd0;
        #1;
        total++;
        if (bus.ic_addr_ok !== 1'b1) begin
            bad++;
            $display("FAIL areset_regrant: got ok=%b want 1", bus.ic_addr_ok);
        end
        @(negedge clk) bus.ic_rd_req = 1'b0;
        #1;
        total++;
        if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd0, 32'h0000_6000}) begin
            bad++;
            $display("FAIL areset_ar: got v=%b id=%0d addr=%h want v=1 id=0 addr=00006000",
                     bus.arvalid, bus.arid, bus.araddr);
        end
        @(negedge clk) bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rlast   = 1'b1;
        bus.rdata   = 32'hD0;
        #1;
        total++;
        if ({bus.ic_rvalid, bus.ic_rlast, bus.rd_beat} !== {2'b11, 8'd0}) begin
            bad++;
            $display("FAIL areset_beat: got v=%b l=%b beat=%0d want v=1 l=1 beat=0",
                     bus.ic_rvalid, bus.ic_rlast, bus.rd_beat);
        end
        @(negedge clk);
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL areset_done: got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_ic_burst();
`ifdef RD_ARB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_priority();
`endif
        test_cancel();
        test_bubbles();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
